id_stage_pipelined: RTL and testbench

Parametrised instruction-decode stage with an integrated ID/EX pipeline register, load-use hazard detection and write-through register-file bypass. It sits between the IF/ID register and the execute stage. It generalises the 16-bit, 8-register combinational decode to configurable widths and register counts. It adds registered outputs, stall, flush and bubble insertion.

---
 rtl/id_pkg.sv | 65 ++++++
 rtl/regfile_bypass.sv | 37 +++
 rtl/id_stage_pipelined.sv | 113 +++++++++++
 tb/tb_id_stage_pipelined.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// rtl/id_pkg.sv - opcode, ALU class and control-bundle definitions for the decode stage
package id_pkg;

  localparam int OP_RTYPE = 0;
  localparam int OP_LW    = 1;
  localparam int OP_SW    = 2;
  localparam int OP_BEQ   = 3;
  localparam int OP_ADDI  = 4;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_FUNC = 2'b10;

  // Instruction width implied by the field widths; the top slices through a vector of this size.
  function automatic int instr_fields_w(int opc_w, int reg_addr_w, int imm_w);
    return opc_w + 2 * reg_addr_w + imm_w;
  endfunction

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(int opcode);
    ctrl_t c;
    c = '0;
    case (opcode)
      OP_RTYPE: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
        c.alu_op    = ALU_FUNC;
      end
      OP_LW: begin
        c.alu_src    = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.mem_read   = 1'b1;
        c.alu_op     = ALU_ADD;
      end
      OP_SW: begin
        c.alu_src   = 1'b1;
        c.mem_write = 1'b1;
        c.alu_op    = ALU_ADD;
      end
      OP_BEQ: begin
        c.branch = 1'b1;
        c.alu_op = ALU_SUB;
      end
      OP_ADDI: begin
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
        c.alu_op    = ALU_ADD;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/regfile_bypass.sv
// rtl/regfile_bypass.sv - register file, two bypassed read ports and one write port
module regfile_bypass #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0]     rd_data_a,
  input  logic [REG_ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0]     rd_data_b,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data
);

  localparam int NUM_REGS = 2 ** REG_ADDR_W;

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en && wr_addr != '0) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Register 0 is hard zero, so the bypass only needs to match nonzero addresses.
  assign rd_data_a = (rd_addr_a == '0)                 ? '0 :
                     (wr_en && wr_addr == rd_addr_a)   ? wr_data :
                                                         regs[rd_addr_a];
  assign rd_data_b = (rd_addr_b == '0)                 ? '0 :
                     (wr_en && wr_addr == rd_addr_b)   ? wr_data :
                                                         regs[rd_addr_b];

endmodule

// File: rtl/id_stage_pipelined.sv
// rtl/id_stage_pipelined.sv - decode stage with ID/EX register, load-use stall and RF bypass
module id_stage_pipelined
  import id_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3,
  parameter int OPC_W      = 3,
  parameter int IMM_W      = 7,
  parameter int INSTR_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_Valid,
  input  logic [INSTR_W-1:0]    i_Instruction,
  input  logic                  i_Flush,
  input  logic                  i_Sig_RegWrite,
  input  logic [REG_ADDR_W-1:0] i_Write_Register,
  input  logic [DATA_W-1:0]     i_Write_Data,
  output logic                  o_Stall,
  output logic                  o_Valid,
  output logic [DATA_W-1:0]     o_A,
  output logic [DATA_W-1:0]     o_B,
  output logic [DATA_W-1:0]     o_extended_Immediate,
  output logic [REG_ADDR_W-1:0] o_Rs,
  output logic [REG_ADDR_W-1:0] o_Rt,
  output logic [REG_ADDR_W-1:0] o_Rd,
  output logic                  o_Sig_RegDst,
  output logic                  o_Sig_ALUSrc,
  output logic                  o_Sig_MemtoReg,
  output logic                  o_Sig_RegWrite,
  output logic                  o_Sig_MemRead,
  output logic                  o_Sig_MemWrite,
  output logic                  o_Sig_Branch,
  output logic [1:0]            o_Sigs_ALUOp
);

  localparam int FIELDS_W = instr_fields_w(OPC_W, REG_ADDR_W, IMM_W);
  localparam int RT_LSB   = IMM_W;
  localparam int RS_LSB   = IMM_W + REG_ADDR_W;
  localparam int OPC_LSB  = IMM_W + 2 * REG_ADDR_W;

  logic [FIELDS_W-1:0]   instr;
  logic [OPC_W-1:0]      opcode;
  logic [REG_ADDR_W-1:0] rs;
  logic [REG_ADDR_W-1:0] rt;
  logic [IMM_W-1:0]      imm;
  logic [DATA_W-1:0]     imm_ext;
  logic [DATA_W-1:0]     rd_data_a;
  logic [DATA_W-1:0]     rd_data_b;
  ctrl_t                 ctrl_d;
  ctrl_t                 ctrl_q;
  logic                  bubble;

  assign instr   = i_Instruction;
  assign opcode  = instr[OPC_LSB +: OPC_W];
  assign rs      = instr[RS_LSB +: REG_ADDR_W];
  assign rt      = instr[RT_LSB +: REG_ADDR_W];
  assign imm     = instr[IMM_W-1:0];
  assign imm_ext = {{(DATA_W - IMM_W){imm[IMM_W-1]}}, imm};
  assign ctrl_d  = decode_ctrl(int'(opcode));

  regfile_bypass #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr_a (rs),
    .rd_data_a (rd_data_a),
    .rd_addr_b (rt),
    .rd_data_b (rd_data_b),
    .wr_en     (i_Sig_RegWrite),
    .wr_addr   (i_Write_Register),
    .wr_data   (i_Write_Data)
  );

  // A load in EX whose destination feeds this instruction must wait one cycle; a flush cancels it.
  assign o_Stall = i_Valid & ~i_Flush & o_Valid & o_Sig_MemRead &
                   ((o_Rt == rs) | (o_Rt == rt));
  assign bubble  = i_Flush | o_Stall | ~i_Valid;

  always_ff @(posedge clk) begin
    if (!rst_n || bubble) begin
      o_Valid              <= 1'b0;
      o_A                  <= '0;
      o_B                  <= '0;
      o_extended_Immediate <= '0;
      o_Rs                 <= '0;
      o_Rt                 <= '0;
      o_Rd                 <= '0;
      ctrl_q               <= '0;
    end else begin
      o_Valid              <= 1'b1;
      o_A                  <= rd_data_a;
      o_B                  <= rd_data_b;
      o_extended_Immediate <= imm_ext;
      o_Rs                 <= rs;
      o_Rt                 <= rt;
      o_Rd                 <= imm[IMM_W-1 -: REG_ADDR_W];
      ctrl_q               <= ctrl_d;
    end
  end

  assign o_Sig_RegDst   = ctrl_q.reg_dst;
  assign o_Sig_ALUSrc   = ctrl_q.alu_src;
  assign o_Sig_MemtoReg = ctrl_q.mem_to_reg;
  assign o_Sig_RegWrite = ctrl_q.reg_write;
  assign o_Sig_MemRead  = ctrl_q.mem_read;
  assign o_Sig_MemWrite = ctrl_q.mem_write;
  assign o_Sig_Branch   = ctrl_q.branch;
  assign o_Sigs_ALUOp   = ctrl_q.alu_op;

endmodule

// File: tb/tb_id_stage_pipelined.sv
// tb/tb_id_stage_pipelined.sv - directed table plus randomized model check, two configurations
module tb_id_stage_pipelined;

  localparam logic [8:0] C_R    = 9'b100100010;
  localparam logic [8:0] C_LW   = 9'b011110000;
  localparam logic [8:0] C_SW   = 9'b010001000;
  localparam logic [8:0] C_BEQ  = 9'b000000101;
  localparam logic [8:0] C_ADDI = 9'b010100000;

  typedef struct packed {
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic [3:0]  rd;
    logic [8:0]  ctrl;
  } mstate_t;

  typedef struct {
    logic        rst_n;
    logic        valid;
    logic        flush;
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [19:0] ins;
    logic        stall;
    mstate_t     exp;
  } vec_t;

  int dw_c  [2] = '{16, 32};
  int aw_c  [2] = '{3, 4};
  int immw_c[2] = '{7, 9};

  logic        clk;
  logic        rst_n;
  logic        valid_i[2];
  logic        flush_i[2];
  logic        we_i[2];
  logic [3:0]  wa_i[2];
  logic [31:0] wd_i[2];
  logic [19:0] ins_i[2];

  wire        stall_w0, valid_w0, stall_w1, valid_w1;
  wire [15:0] a_w0, b_w0, imm_w0;
  wire [31:0] a_w1, b_w1, imm_w1;
  wire [2:0]  rs_w0, rt_w0, rd_w0;
  wire [3:0]  rs_w1, rt_w1, rd_w1;
  wire [8:0]  ctrl_w0, ctrl_w1;

  int n_vec = 0;
  int n_err = 0;

  mstate_t     mst[2];
  logic [31:0] mregs[2][16];
  vec_t        vecs[$];

  id_stage_pipelined u_dut0 (
    .clk(clk), .rst_n(rst_n), .i_Valid(valid_i[0]), .i_Instruction(ins_i[0][15:0]),
    .i_Flush(flush_i[0]), .i_Sig_RegWrite(we_i[0]), .i_Write_Register(wa_i[0][2:0]),
    .i_Write_Data(wd_i[0][15:0]), .o_Stall(stall_w0), .o_Valid(valid_w0),
    .o_A(a_w0), .o_B(b_w0), .o_extended_Immediate(imm_w0),
    .o_Rs(rs_w0), .o_Rt(rt_w0), .o_Rd(rd_w0),
    .o_Sig_RegDst(ctrl_w0[8]), .o_Sig_ALUSrc(ctrl_w0[7]), .o_Sig_MemtoReg(ctrl_w0[6]),
    .o_Sig_RegWrite(ctrl_w0[5]), .o_Sig_MemRead(ctrl_w0[4]), .o_Sig_MemWrite(ctrl_w0[3]),
    .o_Sig_Branch(ctrl_w0[2]), .o_Sigs_ALUOp(ctrl_w0[1:0])
  );

  id_stage_pipelined #(
    .DATA_W(32), .REG_ADDR_W(4), .OPC_W(3), .IMM_W(9), .INSTR_W(20)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_Valid(valid_i[1]), .i_Instruction(ins_i[1]),
    .i_Flush(flush_i[1]), .i_Sig_RegWrite(we_i[1]), .i_Write_Register(wa_i[1]),
    .i_Write_Data(wd_i[1]), .o_Stall(stall_w1), .o_Valid(valid_w1),
    .o_A(a_w1), .o_B(b_w1), .o_extended_Immediate(imm_w1),
    .o_Rs(rs_w1), .o_Rt(rt_w1), .o_Rd(rd_w1),
    .o_Sig_RegDst(ctrl_w1[8]), .o_Sig_ALUSrc(ctrl_w1[7]), .o_Sig_MemtoReg(ctrl_w1[6]),
    .o_Sig_RegWrite(ctrl_w1[5]), .o_Sig_MemRead(ctrl_w1[4]), .o_Sig_MemWrite(ctrl_w1[3]),
    .o_Sig_Branch(ctrl_w1[2]), .o_Sigs_ALUOp(ctrl_w1[1:0])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(int c, mstate_t e, string tag);
    mstate_t o;
    if (c == 0) begin
      o = '{valid_w0, {16'b0, a_w0}, {16'b0, b_w0}, {16'b0, imm_w0},
            {1'b0, rs_w0}, {1'b0, rt_w0}, {1'b0, rd_w0}, ctrl_w0};
    end else begin
      o = '{valid_w1, a_w1, b_w1, imm_w1, rs_w1, rt_w1, rd_w1, ctrl_w1};
    end
    chk({tag, ".valid"}, 32'(o.valid), 32'(e.valid));
    chk({tag, ".a"},     o.a,          e.a);
    chk({tag, ".b"},     o.b,          e.b);
    chk({tag, ".imm"},   o.imm,        e.imm);
    chk({tag, ".rs"},    32'(o.rs),    32'(e.rs));
    chk({tag, ".rt"},    32'(o.rt),    32'(e.rt));
    chk({tag, ".rd"},    32'(o.rd),    32'(e.rd));
    chk({tag, ".ctrl"},  32'(o.ctrl),  32'(e.ctrl));
  endtask

  function automatic logic [19:0] mk_ins(int c, int op, int rs, int rt, int imm);
    int iw = immw_c[c];
    int aw = aw_c[c];
    return 20'((op << (iw + 2 * aw)) | (rs << (iw + aw)) | (rt << iw) | imm);
  endfunction

  function automatic mstate_t mk_exp(logic v, logic [31:0] a, logic [31:0] b, logic [31:0] imm,
                                     int rs, int rt, int rd, logic [8:0] ctrl);
    return '{v, a, b, imm, 4'(rs), 4'(rt), 4'(rd), ctrl};
  endfunction

  task automatic addv(logic r, logic v, logic f, logic we, int wa, logic [31:0] wd,
                      logic [19:0] ins, logic stall, mstate_t e);
    vec_t x;
    x = '{r, v, f, we, 4'(wa), wd, ins, stall, e};
    vecs.push_back(x);
  endtask

  function automatic logic [8:0] ctrl_of(int op);
    case (op)
      0: return C_R;
      1: return C_LW;
      2: return C_SW;
      3: return C_BEQ;
      4: return C_ADDI;
      default: return 9'b0;
    endcase
  endfunction

  function automatic logic [31:0] dmask(int c);
    return (dw_c[c] == 32) ? 32'hFFFF_FFFF : ((32'd1 << dw_c[c]) - 1);
  endfunction

  function automatic int fld(int c, int lsb, int w);
    return int'((32'(ins_i[c]) >> lsb) & ((32'd1 << w) - 1));
  endfunction

  function automatic logic [31:0] read_reg(int c, int r);
    if (r == 0) return 32'd0;
    if (we_i[c] && int'(wa_i[c]) == r) return wd_i[c] & dmask(c);
    return mregs[c][r];
  endfunction

  function automatic logic exp_stall(int c);
    int aw = aw_c[c];
    int iw = immw_c[c];
    int rs = fld(c, iw + aw, aw);
    int rt = fld(c, iw, aw);
    return valid_i[c] && !flush_i[c] && mst[c].valid && mst[c].ctrl[4] &&
           (int'(mst[c].rt) == rs || int'(mst[c].rt) == rt);
  endfunction

  task automatic model_edge(int c, logic stall);
    int aw = aw_c[c];
    int iw = immw_c[c];
    int imm = fld(c, 0, iw);
    mstate_t n;
    if (!rst_n) begin
      mst[c] = '0;
      for (int r = 0; r < 16; r++) mregs[c][r] = 32'd0;
    end else begin
      n = '0;
      if (valid_i[c] && !flush_i[c] && !stall) begin
        n.valid = 1'b1;
        n.rs    = 4'(fld(c, iw + aw, aw));
        n.rt    = 4'(fld(c, iw, aw));
        n.a     = read_reg(c, int'(n.rs));
        n.b     = read_reg(c, int'(n.rt));
        n.imm   = (imm >= (1 << (iw - 1))) ? (32'(imm) - (32'd1 << iw)) & dmask(c) : 32'(imm);
        n.rd    = 4'(imm >> (iw - aw));
        n.ctrl  = ctrl_of(fld(c, iw + 2 * aw, 3));
      end
      if (we_i[c] && wa_i[c] != 4'd0) mregs[c][wa_i[c]] = wd_i[c] & dmask(c);
      mst[c] = n;
    end
  endtask

  initial begin
    logic st[2];
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      valid_i[c] = 0; flush_i[c] = 0; we_i[c] = 0; wa_i[c] = 0; wd_i[c] = 0; ins_i[c] = 0;
      mst[c] = '0;
    end

    // rst, valid, flush, we, wa, wd, instruction, stall before edge, ID/EX after edge
    addv(0, 0, 0, 0, 0, 0,        0,                       0, '0);
    addv(1, 0, 0, 1, 1, 5,        0,                       0, '0);
    addv(1, 0, 0, 1, 2, 7,        0,                       0, '0);
    addv(1, 1, 0, 0, 0, 0,        mk_ins(0, 0, 1, 2, 'h30), 0, mk_exp(1, 5, 7, 'h30, 1, 2, 3, C_R));
    addv(1, 1, 0, 0, 0, 0,        mk_ins(0, 1, 0, 3, 4),    0, mk_exp(1, 0, 0, 4, 0, 3, 0, C_LW));
    addv(1, 1, 0, 0, 0, 0,        mk_ins(0, 4, 3, 5, 1),    1, '0);
    addv(1, 1, 0, 0, 0, 0,        mk_ins(0, 4, 3, 5, 1),    0, mk_exp(1, 0, 0, 1, 3, 5, 0, C_ADDI));
    addv(1, 1, 0, 1, 4, 'h1234,   mk_ins(0, 4, 4, 0, 'h7F), 0, mk_exp(1, 'h1234, 0, 'hFFFF, 4, 0, 7, C_ADDI));
    addv(1, 1, 0, 1, 0, 'hBEEF,   mk_ins(0, 0, 0, 4, 'h3F), 0, mk_exp(1, 0, 'h1234, 'h3F, 0, 4, 3, C_R));
    addv(1, 1, 0, 0, 0, 0,        mk_ins(0, 0, 0, 0, 0),    0, mk_exp(1, 0, 0, 0, 0, 0, 0, C_R));
    addv(1, 1, 0, 0, 0, 0,        mk_ins(0, 1, 4, 6, 0),    0, mk_exp(1, 'h1234, 0, 0, 4, 6, 0, C_LW));
    addv(1, 1, 1, 0, 0, 0,        mk_ins(0, 0, 6, 1, 0),    0, '0);
    addv(1, 1, 0, 0, 0, 0,        mk_ins(0, 1, 0, 2, 0),    0, mk_exp(1, 0, 7, 0, 0, 2, 0, C_LW));
    addv(0, 1, 0, 0, 0, 0,        mk_ins(0, 3, 1, 2, 0),    1, '0);
    addv(1, 1, 0, 0, 0, 0,        mk_ins(0, 3, 1, 2, 0),    0, mk_exp(1, 0, 0, 0, 1, 2, 0, C_BEQ));
    addv(1, 1, 0, 0, 0, 0,        mk_ins(0, 5, 1, 2, 5),    0, mk_exp(1, 0, 0, 5, 1, 2, 0, 9'b0));
    addv(1, 1, 0, 0, 0, 0,        mk_ins(0, 2, 0, 0, 'h40), 0, mk_exp(1, 0, 0, 'hFFC0, 0, 0, 4, C_SW));
    addv(1, 0, 0, 0, 0, 0,        0,                       0, '0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n      = vecs[i].rst_n;
      valid_i[0] = vecs[i].valid;
      flush_i[0] = vecs[i].flush;
      we_i[0]    = vecs[i].we;
      wa_i[0]    = vecs[i].wa;
      wd_i[0]    = vecs[i].wd;
      ins_i[0]   = vecs[i].ins;
      #1;
      chk($sformatf("dir%0d.stall", i), 32'(stall_w0), 32'(vecs[i].stall));
      @(posedge clk);
      #1;
      check_outputs(0, vecs[i].exp, $sformatf("dir%0d", i));
    end

    for (int it = 0; it < 1500; it++) begin
      @(negedge clk);
      rst_n = (it == 0) ? 1'b0 : ($urandom_range(0, 59) != 0);
      for (int c = 0; c < 2; c++) begin
        int aw = aw_c[c];
        int op = ($urandom_range(0, 2) == 0) ? 1 : int'($urandom_range(0, 7));
        int rs = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, (1 << aw) - 1));
        int rt = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, (1 << aw) - 1));
        int imm = int'($urandom_range(0, (1 << immw_c[c]) - 1));
        valid_i[c] = ($urandom_range(0, 4) != 0);
        flush_i[c] = ($urandom_range(0, 9) == 0);
        we_i[c]    = $urandom_range(0, 1);
        wa_i[c]    = 4'($urandom_range(0, (1 << aw) - 1));
        wd_i[c]    = $urandom;
        ins_i[c]   = mk_ins(c, op, rs, rt, imm);
      end
      #1;
      for (int c = 0; c < 2; c++) begin
        st[c] = exp_stall(c);
        chk($sformatf("rnd%0d.c%0d.stall", it, c), 32'(c == 0 ? stall_w0 : stall_w1), 32'(st[c]));
      end
      @(posedge clk);
      for (int c = 0; c < 2; c++) model_edge(c, st[c]);
      #1;
      for (int c = 0; c < 2; c++) check_outputs(c, mst[c], $sformatf("rnd%0d.c%0d", it, c));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
